tdm_demux_1x4: RTL and testbench

//  Receive end of the team's 4-slot time-division link; the send side selects one of four

---
 rtl/tdm_demux_1x4.sv | 88 ++++++++
 tb/tb_tdm_demux_1x4.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x4.sv
// Receive side of the 4-slot TDM link: steers beats into slots, publishes y0..y3 on the edge taking slot 3.
// No backpressure: every in_valid beat is consumed; out_valid/frame_err are 1-cycle pulses.
module tdm_demux_1x4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         out_valid,
  output logic [1:0]   s,
  output logic         frame_err
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [1:0]         s_nxt;
  logic [2:0][W-1:0]  shadow, shadow_nxt;
  logic [W-1:0]       y0_nxt, y1_nxt, y2_nxt, y3_nxt;
  logic               out_valid_nxt, frame_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= 2'd0;
      shadow    <= '0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      shadow    <= shadow_nxt;
      y0        <= y0_nxt;
      y1        <= y1_nxt;
      y2        <= y2_nxt;
      y3        <= y3_nxt;
      out_valid <= out_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    s_nxt         = s;
    shadow_nxt    = shadow;
    y0_nxt        = y0;
    y1_nxt        = y1;
    y2_nxt        = y2;
    y3_nxt        = y3;
    out_valid_nxt = 1'b0;
    frame_err_nxt = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        // An SOF while collecting abandons the partial frame but still starts a new one.
        frame_err_nxt = (state == COLLECT);
        shadow_nxt[0] = in_data;
        s_nxt         = 2'd1;
        state_nxt     = COLLECT;
      end else if (state == IDLE) begin
        frame_err_nxt = 1'b1;
      end else if (s == 2'd3) begin
        y0_nxt        = shadow[0];
        y1_nxt        = shadow[1];
        y2_nxt        = shadow[2];
        y3_nxt        = in_data;
        out_valid_nxt = 1'b1;
        s_nxt         = 2'd0;
        state_nxt     = IDLE;
      end else begin
        if (s == 2'd1) shadow_nxt[1] = in_data;
        else           shadow_nxt[2] = in_data;
        s_nxt = s + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Scoreboard bench: a frame-assembly model queues expected pulses; a negedge monitor pops and compares.
module tb_tdm_demux_1x4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] y0, y1, y2, y3;
  logic         out_valid, frame_err;
  logic [1:0]   s;

  tdm_demux_1x4 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid), .s(s), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] ys;   // {y3,y2,y1,y0}
  } ev_t;

  logic [W-1:0] partial[$];
  ev_t          expq[$];
  logic [31:0]  last_y = '0;
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: a frame is an SOF beat followed by three plain beats, held as a list.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      if (in_sof) begin
        if (partial.size() != 0) expq.push_back('{err: 1'b1, ys: 32'h0});
        partial.delete();
        partial.push_back(in_data);
      end else if (partial.size() == 0) begin
        expq.push_back('{err: 1'b1, ys: 32'h0});
      end else begin
        partial.push_back(in_data);
        if (partial.size() == 4) begin
          expq.push_back('{err: 1'b0, ys: {partial[3], partial[2], partial[1], partial[0]}});
          partial.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      chk("s", {30'd0, s}, partial.size());
      chk("pulse_overlap", {31'd0, out_valid & frame_err}, 32'd0);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, ~e.err});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
        if (!e.err) last_y = e.ys;
      end else begin
        chk("no_pulse", {30'd0, out_valid, frame_err}, 32'd0);
      end
      chk("y", {y3, y2, y1, y0}, last_y);
    end
  end

  task automatic beat(input logic v, input logic sof, input logic [W-1:0] d);
    @(posedge clk);
    #2;
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input logic [31:0] f, input int g);
    beat(1'b1, 1'b1, f[7:0]);   gap(g);
    beat(1'b1, 1'b0, f[15:8]);  gap(g);
    beat(1'b1, 1'b0, f[23:16]); gap(g);
    beat(1'b1, 1'b0, f[31:24]);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_y"}, {y3, y2, y1, y0}, 32'd0);
    chk({tag, "_s"}, {30'd0, s}, 32'd0);
    chk({tag, "_pulses"}, {30'd0, out_valid, frame_err}, 32'd0);
  endtask

  initial begin
    #1 check_reset_values("por");
    #20;
    @(posedge clk); #2 rst_n = 1'b1;

    frame(32'hD4C3B2A1, 0);   gap(3);
    frame(32'h44332211, 2);   gap(3);
    beat(1'b1, 1'b1, 8'h11); beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b1, 8'h33); beat(1'b1, 1'b0, 8'h44);
    beat(1'b1, 1'b0, 8'h55); beat(1'b1, 1'b0, 8'h66);
    gap(3);
    beat(1'b1, 1'b0, 8'h77); gap(3);
    beat(1'b0, 1'b1, 8'h99); gap(3);
    frame(32'h01020304, 0);
    frame(32'hA0B0C0D0, 0);
    frame(32'h5A6B7C8D, 0);   gap(3);

    // Reset in the cycle where out_valid is high, with y holding a frame.
    frame(32'hCAFEF00D, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    partial.delete();
    expq.delete();
    last_y = '0;
    #1 check_reset_values("async_rst");
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset mid-frame: the partial frame must not survive.
    beat(1'b1, 1'b1, 8'hE1); beat(1'b1, 1'b0, 8'hE2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    partial.delete();
    expq.delete();
    last_y = '0;
    #1 check_reset_values("midframe_rst");
    @(posedge clk); #2 rst_n = 1'b1;
    beat(1'b1, 1'b0, 8'hE3); gap(2);

    for (int i = 0; i < 600; i++) begin
      int r;
      logic sof;
      r = $urandom_range(0, 9);
      sof = (partial.size() == 0) ? (r < 8) : (r == 0);
      beat($urandom_range(0, 9) < 7, sof, 8'($urandom));
    end
    gap(4);
    chk("queue_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
